// File: rtl/beta_timer_pkg.sv
// Shared register-map and bit-index constants for the Beta interval timer.
package beta_timer_pkg;

  // Word offsets within the register window (addr[4:2])
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_COUNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  // CTRL bit positions
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_RELOAD = 1;
  localparam int unsigned CTRL_IE     = 2;
  localparam int unsigned CTRL_W      = 3;

  // STATUS bit positions
  localparam int unsigned STATUS_PEND = 0;

endpackage

// File: rtl/beta_timer_irq_prescaler.sv
// Prescaler: counts 0..limit while enabled and pulses tick on the terminal count.
module beta_timer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = en && (pcnt == limit);

  // Advance the prescale count, wrapping at limit; held at zero when disabled or cleared
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (clear || !en || (pcnt == limit)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/beta_timer_irq.sv
// Memory-mapped interval timer with level interrupt for the Beta data bus.
module beta_timer_irq #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        irq
);

  import beta_timer_pkg::*;

  logic [CTRL_W-1:0]     ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           compare;
  logic [31:0]           count;
  logic                  pend;
  logic [2:0]            off;
  logic                  wr;
  logic                  tick;
  logic                  match;
  logic                  pscClear;
  logic                  unusedBits;

  assign sel      = (addr[31:5] == BASE_ADDR[31:5]);
  assign off      = addr[4:2];
  assign wr       = we && sel;
  assign match    = (count == compare);
  assign pscClear = wr && ((off == OFF_CTRL) || (off == OFF_PRESCALE));
  assign irq      = pend && ctrl[CTRL_IE];

  // Byte lane bits and the load strobe carry no meaning inside the timer
  assign unusedBits = ^{addr[1:0], re};

  beta_timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) uPrescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl[CTRL_EN]),
    .clear(pscClear),
    .limit(prescale),
    .tick (tick)
  );

  // Register file and counter; the bus write is applied after the tick update so a
  // same-cycle store to CTRL or COUNT takes precedence, while a STATUS clear yields to a match
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= '0;
      count    <= '0;
      pend     <= 1'b0;
    end else begin
      if (tick) begin
        if (match) begin
          pend  <= 1'b1;
          count <= '0;
          if (!ctrl[CTRL_RELOAD]) begin
            ctrl[CTRL_EN] <= 1'b0;
          end
        end else begin
          count <= count + 32'd1;
        end
      end
      if (wr) begin
        case (off)
          OFF_CTRL:     ctrl     <= wdata[CTRL_W-1:0];
          OFF_PRESCALE: prescale <= wdata[PRESCALE_W-1:0];
          OFF_COMPARE:  compare  <= wdata;
          OFF_COUNT:    count    <= wdata;
          OFF_STATUS: begin
            if (wdata[STATUS_PEND] && !(tick && match)) begin
              pend <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read mux: combinational from register state, zero when not selected
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        OFF_CTRL:     rdata = {29'd0, ctrl};
        OFF_PRESCALE: rdata = 32'(prescale);
        OFF_COMPARE:  rdata = compare;
        OFF_COUNT:    rdata = count;
        OFF_STATUS:   rdata = {31'd0, pend};
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/beta_timer_irq.md
Name: beta_timer_irq

Overview:
Memory-mapped interval timer and interrupt source on the Beta data bus. It decodes the processor's data address, write-data and enables, and returns read data for the bus mux. It drives the Beta's irq input. A handler writes STATUS to acknowledge the interrupt.

Parameters:
BASE_ADDR, 32'hFFFF_0000, byte base address of the 32-byte register window (bits [4:0] must be zero)
PRESCALE_W, 16, width of the prescaler register and counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-low reset (0 = reset)
addr  input  32  data byte address from the Beta
wdata  input  32  store data from the Beta
we  input  1  store strobe, one cycle per store
re  input  1  load strobe; loads have no side effects
rdata  output  32  register read data, valid in the same cycle as addr/re
sel  output  1  1 when addr[31:5] == BASE_ADDR[31:5]; the bus mux uses it to select rdata
irq  output  1  level interrupt request to the Beta

Behaviour:
- Register map, word offset addr[4:2]:
  - 0 CTRL: bit0 EN, bit1 RELOAD, bit2 IE; other bits read 0.
  - 1 PRESCALE: PRESCALE_W bits, zero-extended on read.
  - 2 COMPARE: 32 bits.
  - 3 COUNT: 32 bits.
  - 4 STATUS: bit0 PEND; writing 1 to bit0 clears PEND, writing 0 has no effect.
  - 5-7: read 0, writes ignored.
- Write: takes effect at the rising edge when we=1 and sel=1. addr[1:0] is ignored; only full-word stores.
- Read: rdata is combinational from register state whenever sel=1. When sel=0, rdata=0. re only qualifies external use.
- Reset (rst=0 at an edge): CTRL, PRESCALE, COMPARE, COUNT, PEND and the prescaler counter all 0. Consequences: irq=0, rdata=0 when sel=0.
- Reset mid-count: all state cleared in that cycle, and any same-cycle bus write is discarded.
- Prescaler:
  - pcnt counts 0..PRESCALE while EN=1.
  - tick=1 in the cycle pcnt==PRESCALE, then pcnt wraps to 0.
  - PRESCALE=0 gives a tick every cycle.
  - EN=0 holds pcnt at 0.
  - A write to PRESCALE or CTRL forces pcnt to 0.
- Counter, on tick with EN=1:
  - COUNT==COMPARE: PEND<=1; COUNT<=0. If RELOAD=0, EN<=0 (one-shot).
  - Otherwise COUNT<=COUNT+1, wrapping 32'hFFFF_FFFF to 0 modulo 2^32 with no flag.
- Simultaneous events:
  - A bus write to COUNT or CTRL wins over the tick update of the same register in that cycle.
  - A compare-match set of PEND wins over a same-cycle STATUS clear, so no interrupt is lost.
- irq = PEND & IE, derived from flops only (no combinational path from bus inputs). Clearing IE masks irq but leaves PEND set.
- Latency:
  - A match tick sets PEND and irq at the next edge.
  - A STATUS write drops irq after that edge.
  - A CTRL write with EN=1 and PRESCALE=0 gives its first COUNT increment at the following edge.

Decomposition:
- Shared package beta_timer_pkg holds:
  - register offset localparams: OFF_CTRL=0, OFF_PRESCALE=1, OFF_COMPARE=2, OFF_COUNT=3, OFF_STATUS=4
  - CTRL bit indices: EN=0, RELOAD=1, IE=2
  - STATUS_PEND=0
- One sub-module, beta_timer_prescaler: clk, rst, en, clear, limit[PRESCALE_W-1:0] -> tick.
- Decode, register file, counter and irq logic live in beta_timer_irq.

Test Plan:
- Reset: hold rst=0 for 3 cycles with we=1 to BASE+0x0, data 7 -> CTRL reads 0, irq=0, and a read at BASE+0x1C returns 0 with sel=1.
- Auto-reload: PRESCALE=0, COMPARE=3, CTRL=0x7 -> COUNT sequence 1,2,3,0. PEND/irq rise on the edge where COUNT returns to 0 and repeat every 4 cycles. A STATUS write of 1 drops irq on the next edge.
- One-shot with prescale: PRESCALE=2, COMPARE=1, CTRL=0x5 -> COUNT increments every 3 cycles. On match PEND=1, CTRL reads 0x4, and COUNT stays 0 thereafter.
- Set/clear collision: time a STATUS=1 write onto the match-tick cycle -> PEND stays 1 and irq stays high.
- Write priority and wrap: COMPARE=0, CTRL=0x3, write COUNT=0xFFFF_FFFF -> next tick COUNT=0 with no PEND. A COUNT write on a tick cycle stores the written value.
- Decode/masking: access at BASE+0x20 -> sel=0, rdata=0, no state change. With IE=0 and a match, PEND=1 but irq=0. Setting IE=1 raises irq after that edge.
